// File: rtl/bus_bridge_pkg.sv
`default_nettype none
// ---- bus_bridge_pkg : state encoding and default address map for bus_bridge ---- rev 1.0
package bus_bridge_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [31:0] DEF_DEV0_BASE = 32'h0000_7F00;
  localparam logic [31:0] DEF_DEV1_BASE = 32'h0000_7F10;
  localparam logic [31:0] DEF_IMR_ADDR  = 32'h0000_7F20;

endpackage
`default_nettype wire

// File: rtl/bus_addr_decode.sv
`default_nettype none
// ---- bus_addr_decode : word address to device / IMR / unmapped select ---- rev 1.0
module bus_addr_decode
  import bus_bridge_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEF_DEV0_BASE,
  parameter logic [31:0] DEV1_BASE = DEF_DEV1_BASE,
  parameter logic [31:0] IMR_ADDR  = DEF_IMR_ADDR
) (
  input  logic [29:0] word_addr,
  output logic        sel_dev0,
  output logic        sel_dev1,
  output logic        sel_imr,
  output logic        unmapped
);

  // Device windows are four words wide but only words 0..2 exist; word 3 is reserved.
  always_comb begin
    sel_dev0 = (word_addr[29:2] == DEV0_BASE[31:4]) && (word_addr[1:0] != 2'b11);
    sel_dev1 = !sel_dev0 &&
               (word_addr[29:2] == DEV1_BASE[31:4]) && (word_addr[1:0] != 2'b11);
    sel_imr  = !sel_dev0 && !sel_dev1 && (word_addr == IMR_ADDR[31:2]);
    unmapped = !(sel_dev0 || sel_dev1 || sel_imr);
  end

endmodule
`default_nettype wire

// File: rtl/bus_bridge.sv
`default_nettype none
// ---- bus_bridge : CPU to two-device register bridge with masked interrupts ---- rev 1.0
module bus_bridge
  import bus_bridge_pkg::*;
#(
  parameter logic [31:0] DEV0_BASE = DEF_DEV0_BASE,
  parameter logic [31:0] DEV1_BASE = DEF_DEV1_BASE,
  parameter logic [31:0] IMR_ADDR  = DEF_IMR_ADDR
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [1:0]  hwint,
  output logic [1:0]  ADD_O,
  output logic [31:0] DAT_O,
  output logic        WE0_O,
  output logic        WE1_O,
  input  logic [31:0] DAT0_I,
  input  logic [31:0] DAT1_I,
  input  logic        IRQ0_I,
  input  logic        IRQ1_I
);

  logic [1:0]  r_state;
  logic        r_we;
  logic [29:0] r_word_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_imr;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [1:0]  r_hwint;

  logic        w_sel_dev0;
  logic        w_sel_dev1;
  logic        w_sel_imr;
  logic        w_unmapped;
  logic        w_in_access;
  logic [31:0] w_rdata_next;

  // Byte lanes are not used: every access is a full word.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^cpu_addr[1:0];

  bus_addr_decode #(
    .DEV0_BASE (DEV0_BASE),
    .DEV1_BASE (DEV1_BASE),
    .IMR_ADDR  (IMR_ADDR)
  ) u_decode (
    .word_addr (r_word_addr),
    .sel_dev0  (w_sel_dev0),
    .sel_dev1  (w_sel_dev1),
    .sel_imr   (w_sel_imr),
    .unmapped  (w_unmapped)
  );

  assign w_in_access = (r_state == ST_ACCESS);

  always_comb begin
    w_rdata_next = 32'h0;
    if (!r_we) begin
      if (w_sel_dev0)
        w_rdata_next = DAT0_I;
      else if (w_sel_dev1)
        w_rdata_next = DAT1_I;
      else if (w_sel_imr)
        w_rdata_next = {30'h0, r_imr};
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_word_addr <= 30'h0;
      r_wdata     <= 32'h0;
      r_imr       <= 2'b00;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
      r_hwint     <= 2'b00;
    end else begin
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_hwint <= {IRQ1_I, IRQ0_I} & r_imr;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_state     <= ST_ACCESS;
            r_we        <= cpu_we;
            r_word_addr <= cpu_addr[31:2];
            r_wdata     <= cpu_wdata;
          end
        end
        ST_ACCESS: begin
          r_state <= ST_RESP;
          r_ack   <= 1'b1;
          r_err   <= w_unmapped;
          r_rdata <= w_rdata_next;
          if (r_we && w_sel_imr)
            r_imr <= r_wdata[1:0];
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded from the latched transaction, so they exist only in ACCESS.
  assign WE0_O     = w_in_access && r_we && w_sel_dev0;
  assign WE1_O     = w_in_access && r_we && w_sel_dev1;
  assign ADD_O     = r_word_addr[1:0];
  assign DAT_O     = r_wdata;
  assign cpu_ack   = r_ack;
  assign cpu_err   = r_err;
  assign cpu_rdata = r_rdata;
  assign hwint     = r_hwint;

endmodule
`default_nettype wire

// File: tb/tb_bus_bridge.sv
`default_nettype none
// ---- tb_bus_bridge : directed vector bench for bus_bridge ---- rev 1.0
module tb_bus_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [1:0]  hwint;
  logic [1:0]  add_o;
  logic [31:0] dat_o;
  logic        we0;
  logic        we1;
  logic [31:0] dat0;
  logic [31:0] dat1;
  logic        irq0;
  logic        irq1;

  int n_total = 0;
  int n_pass  = 0;
  logic [1:0] hwint_at_resp;

  always #5 clk = ~clk;

  bus_bridge dut (
    .CLK_I     (clk),
    .RST_I     (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .cpu_err   (cpu_err),
    .hwint     (hwint),
    .ADD_O     (add_o),
    .DAT_O     (dat_o),
    .WE0_O     (we0),
    .WE1_O     (we1),
    .DAT0_I    (dat0),
    .DAT1_I    (dat1),
    .IRQ0_I    (irq0),
    .IRQ1_I    (irq1)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] dat0;
    logic [31:0] dat1;
    logic        exp_we0;
    logic        exp_we1;
    logic [1:0]  exp_add;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic add_vec(input string nm, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] d0, input logic [31:0] d1,
                         input logic ew0, input logic ew1, input logic [1:0] eadd,
                         input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.name = nm; v.we = we; v.addr = addr; v.wdata = wdata; v.dat0 = d0; v.dat1 = d1;
    v.exp_we0 = ew0; v.exp_we1 = ew1; v.exp_add = eadd; v.exp_rdata = erd; v.exp_err = eerr;
    vq.push_back(v);
  endtask

  // One complete transaction from IDLE: request, ACCESS cycle, RESP cycle, back in IDLE.
  task automatic do_txn(input string nm, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic ew0, input logic ew1,
                        input logic [1:0] eadd, input logic [31:0] erd, input logic eerr);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    chk({nm, ".we0"}, {31'h0, we0}, {31'h0, ew0});
    chk({nm, ".we1"}, {31'h0, we1}, {31'h0, ew1});
    chk({nm, ".add"}, {30'h0, add_o}, {30'h0, eadd});
    chk({nm, ".dat"}, dat_o, wdata);
    chk({nm, ".ack_early"}, {31'h0, cpu_ack}, 32'h0);
    @(negedge clk);
    chk({nm, ".ack"}, {31'h0, cpu_ack}, 32'h1);
    chk({nm, ".err"}, {31'h0, cpu_err}, {31'h0, eerr});
    chk({nm, ".rdata"}, cpu_rdata, erd);
    chk({nm, ".we_resp"}, {30'h0, we1, we0}, 32'h0);
    hwint_at_resp = hwint;
    cpu_req = 1'b0;
    @(negedge clk);
    chk({nm, ".ack_done"}, {31'h0, cpu_ack}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dat0 = 32'h0; dat1 = 32'h0; irq0 = 1'b0; irq1 = 1'b0;

    add_vec("wr_dev0_ctrl",  1'b1, 32'h7F00, 32'h0000_0009, 32'h0,         32'h0,    1'b1, 1'b0, 2'd0, 32'h0,         1'b0);
    add_vec("rd_dev1_count", 1'b0, 32'h7F18, 32'h0,         32'h0,         32'h1234, 1'b0, 1'b0, 2'd2, 32'h0000_1234, 1'b0);
    add_vec("rd_dev0_rsvd",  1'b0, 32'h7F0C, 32'h0,         32'hDEAD,      32'h0,    1'b0, 1'b0, 2'd3, 32'h0,         1'b1);
    add_vec("rd_unmap_8000", 1'b0, 32'h8000, 32'h0,         32'hAAAA,      32'hBBBB, 1'b0, 1'b0, 2'd0, 32'h0,         1'b1);
    add_vec("wr_dev1_preset",1'b1, 32'h7F14, 32'h0000_00A5, 32'h0,         32'h0,    1'b0, 1'b1, 2'd1, 32'h0,         1'b0);
    add_vec("rd_dev0_preset",1'b0, 32'h7F04, 32'h0,         32'hCAFE_F00D, 32'h12,   1'b0, 1'b0, 2'd1, 32'hCAFE_F00D, 1'b0);
    add_vec("wr_dev1_rsvd",  1'b1, 32'h7F1C, 32'h0000_0077, 32'h0,         32'h0,    1'b0, 1'b0, 2'd3, 32'h0,         1'b1);
    add_vec("wr_imr",        1'b1, 32'h7F20, 32'hFFFF_FFFE, 32'h0,         32'h0,    1'b0, 1'b0, 2'd0, 32'h0,         1'b0);
    add_vec("rd_imr",        1'b0, 32'h7F20, 32'h0,         32'h5,         32'h6,    1'b0, 1'b0, 2'd0, 32'h2,         1'b0);
    add_vec("rd_imr_byte",   1'b0, 32'h7F22, 32'h0,         32'h0,         32'h0,    1'b0, 1'b0, 2'd0, 32'h2,         1'b0);
    add_vec("wr_imr_clear",  1'b1, 32'h7F20, 32'h0,         32'h0,         32'h0,    1'b0, 1'b0, 2'd0, 32'h0,         1'b0);
    add_vec("rd_past_imr",   1'b0, 32'h7F24, 32'h0,         32'h9,         32'h9,    1'b0, 1'b0, 2'd1, 32'h0,         1'b1);
    add_vec("wr_unmap_zero", 1'b1, 32'h0000, 32'h3,         32'h0,         32'h0,    1'b0, 1'b0, 2'd0, 32'h0,         1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ack",   {31'h0, cpu_ack}, 32'h0);
    chk("rst.err",   {31'h0, cpu_err}, 32'h0);
    chk("rst.rdata", cpu_rdata, 32'h0);
    chk("rst.hwint", {30'h0, hwint}, 32'h0);
    chk("rst.we",    {30'h0, we1, we0}, 32'h0);
    chk("rst.add",   {30'h0, add_o}, 32'h0);
    chk("rst.dat",   dat_o, 32'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      dat0 = vq[i].dat0;
      dat1 = vq[i].dat1;
      do_txn(vq[i].name, vq[i].we, vq[i].addr, vq[i].wdata, vq[i].exp_we0, vq[i].exp_we1,
             vq[i].exp_add, vq[i].exp_rdata, vq[i].exp_err);
    end

    // Interrupt masking and level following
    @(negedge clk);
    irq0 = 1'b1; irq1 = 1'b1;
    repeat (2) @(negedge clk);
    chk("irq.masked", {30'h0, hwint}, 32'h0);
    do_txn("imr_set0", 1'b1, 32'h7F20, 32'h1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    chk("irq.latency", {30'h0, hwint_at_resp}, 32'h0);
    chk("irq.unmasked", {30'h0, hwint}, 32'h1);
    irq0 = 1'b0;
    @(negedge clk);
    chk("irq.dropped", {30'h0, hwint}, 32'h0);

    // Reset landing in the ACCESS cycle of a device-1 write
    irq0 = 1'b1;
    @(negedge clk);
    chk("abort.hwint_pre", {30'h0, hwint}, 32'h1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F10; cpu_wdata = 32'h5;
    @(negedge clk);
    chk("abort.we1_access", {31'h0, we1}, 32'h1);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    chk("abort.we1_rst", {31'h0, we1}, 32'h0);
    chk("abort.ack_rst", {31'h0, cpu_ack}, 32'h0);
    chk("abort.dat_rst", dat_o, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort.ack_after", {31'h0, cpu_ack}, 32'h0);
    chk("abort.hwint_after", {30'h0, hwint}, 32'h0);
    do_txn("abort.rd_imr", 1'b0, 32'h7F20, 32'h0, 1'b0, 1'b0, 2'd0, 32'h0, 1'b0);
    do_txn("abort.retry", 1'b1, 32'h7F10, 32'h5, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0);
    irq0 = 1'b0; irq1 = 1'b0;

    // Back-to-back with cpu_req held high across both transactions
    dat0 = 32'h0; dat1 = 32'h55;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F08; cpu_wdata = 32'h7;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("b2b.ack_c%0d", c), {31'h0, cpu_ack}, {31'h0, (c == 1 || c == 4)});
      chk($sformatf("b2b.we0_c%0d", c), {31'h0, we0}, {31'h0, (c == 0)});
      chk($sformatf("b2b.we1_c%0d", c), {31'h0, we1}, 32'h0);
      if (c == 1) begin
        chk("b2b.err1", {31'h0, cpu_err}, 32'h0);
        chk("b2b.rdata1", cpu_rdata, 32'h0);
        cpu_we = 1'b0; cpu_addr = 32'h7F14; cpu_wdata = 32'h0;
      end
      if (c == 3)
        chk("b2b.add2", {30'h0, add_o}, 32'h1);
      if (c == 4) begin
        chk("b2b.err2", {31'h0, cpu_err}, 32'h0);
        chk("b2b.rdata2", cpu_rdata, 32'h55);
        cpu_req = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_bridge.md
BUS_BRIDGE -- requirements
Module: bus_bridge

Interface
REQ-001 Parameter DEV0_BASE, default 32'h0000_7F00, base address of device 0 (3 words: CTRL, PRESET, COUNT).
REQ-002 Parameter DEV1_BASE, default 32'h0000_7F10, base address of device 1 (3 words).
REQ-003 Parameter IMR_ADDR, default 32'h0000_7F20, address of the bridge's own interrupt mask register.
REQ-004 CLK_I  in  1  single clock; all logic on its rising edge.
REQ-005 RST_I  in  1  reset, synchronous, active-high.
REQ-006 cpu_req  in  1  CPU access request; held high until cpu_ack.
REQ-007 cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
REQ-008 cpu_addr  in  32  byte address; stable while cpu_req is high.
REQ-009 cpu_wdata  in  32  write data; stable while cpu_req is high.
REQ-010 cpu_ack  out  1  one-cycle pulse; access complete.
REQ-011 cpu_rdata  out  32  read data; valid in the cpu_ack cycle and held until the next ack.
REQ-012 cpu_err  out  1  pulses with cpu_ack when the address is unmapped.
REQ-013 hwint  out  2  registered, masked interrupt lines to the CPU, bit n = device n.
REQ-014 ADD_O  out  2  word select driven to devices: addr[3:2].
REQ-015 DAT_O  out  32  write data driven to devices.
REQ-016 WE0_O / WE1_O  out  1 each  write strobe for device 0 / device 1.
REQ-017 DAT0_I / DAT1_I  in  32 each  read data from device 0 / device 1.
REQ-018 IRQ0_I / IRQ1_I  in  1 each  level interrupt from device 0 / device 1.

Function
REQ-019 FSM states: IDLE, ACCESS, RESP; IDLE -> ACCESS when cpu_req=1; ACCESS -> RESP unconditionally; RESP -> IDLE unconditionally.
REQ-020 On the IDLE->ACCESS transition, latch cpu_we, cpu_addr and cpu_wdata; later changes on CPU inputs have no effect on the transaction.
REQ-021 Decode: addr[31:4]==DEVn_BASE[31:4] with addr[3:2]!=2'b11 selects device n; addr[31:2]==IMR_ADDR[31:2] selects IMR; everything else is unmapped.
REQ-022 In ACCESS, drive ADD_O=addr[3:2] and DAT_O=wdata; assert WEn_O for exactly that one cycle only if the transaction is a write to device n.
REQ-023 Outside ACCESS, WE0_O=WE1_O=0; ADD_O and DAT_O hold the latched values.
REQ-024 On ACCESS->RESP, register cpu_rdata: DATn_I of the selected device for a device read, {30'b0, IMR} for an IMR read, 32'b0 for writes and unmapped accesses.
REQ-025 In RESP, cpu_ack=1 for one cycle; cpu_err=1 in the same cycle for an unmapped address. Unmapped writes assert no strobe.
REQ-026 Latency: cpu_req sampled high at edge k gives cpu_ack high in cycle k+2. A request still high in the RESP cycle is not restarted; the next transaction starts only on a cpu_req sampled in IDLE.
REQ-027 An IMR write updates IMR[1:0]<=wdata[1:0] on the ACCESS->RESP edge; wdata[31:2] are ignored.
REQ-028 Each clock, hwint[n] <= IRQn_I & IMR[n]; this gives one cycle of latency from an IRQ level or an IMR change.
REQ-029 Interrupts are level-based with no latching: hwint follows the device level, and the device is responsible for clearing it.

Reset
REQ-030 While RST_I=1 at a clock edge: state=IDLE, cpu_ack=0, cpu_err=0, cpu_rdata=0, hwint=0, IMR=0, WE0_O=WE1_O=0, ADD_O=0, DAT_O=0.
REQ-031 Reset during ACCESS or RESP aborts the transaction: no ack, no further strobes. The CPU must re-issue the request.

Structure
REQ-032 A shared package holds the state encoding (IDLE/ACCESS/RESP) and the default base-address constants.
REQ-033 A single combinational sub-module, bus_addr_decode, maps addr to {sel_dev0, sel_dev1, sel_imr, unmapped}; all other logic stays in bus_bridge.

Verification
REQ-034 Write 0x0000_0009 to 0x7F00 -> WE0_O high exactly one cycle (cycle k+1), ADD_O=0, DAT_O=9; cpu_ack at k+2; WE1_O stays 0.
REQ-035 Read 0x7F18 with DAT1_I=0x1234 -> ADD_O=2'b10, cpu_rdata=0x0000_1234 with cpu_ack at k+2, cpu_err=0.
REQ-036 Read 0x7F0C (reserved word) and 0x8000 -> no WE strobe, cpu_rdata=0, cpu_ack and cpu_err both pulse.
REQ-037 IRQ0_I=1 with IMR=0 -> hwint=0; write 0x1 to 0x7F20 -> hwint[0]=1 one cycle after the IMR update; IRQ0_I drops -> hwint[0]=0 the next cycle.
REQ-038 Assert RST_I in the ACCESS cycle of a device-1 write -> no cpu_ack, WE1_O=0 from the reset edge, IMR=0. A fresh request afterwards completes normally.
REQ-039 Back-to-back: cpu_req held high across two transactions -> acks at cycles k+2 and k+5, with both transactions decoded correctly.
